i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_slave_if.sv | 23 ++
 rtl/i2c_slave.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_if.sv
// I2C target bus bundle: line levels/drives plus the byte-stream side toward the user logic.
interface i2c_slave_if;
  logic       i2c_sda_i;
  logic       i2c_scl_i;
  logic       i2c_sda_o;
  logic       i2c_scl_o;
  logic [7:0] data_transmit_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] data_receive_o;
  logic       rx_valid_o;
  logic [7:0] status_o;

  modport slave (
    input  i2c_sda_i, i2c_scl_i, data_transmit_i, tx_valid_i,
    output i2c_sda_o, i2c_scl_o, tx_ready_o, data_receive_o, rx_valid_o, status_o
  );

  modport master (
    output i2c_sda_i, i2c_scl_i, data_transmit_i, tx_valid_i,
    input  i2c_sda_o, i2c_scl_o, tx_ready_o, data_receive_o, rx_valid_o, status_o
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target with 7-bit address, byte-stream read/write side and status flags.
// Optional macro I2C_SLAVE_CLK_STRETCH_EN: stretch SCL on read instead of sending 8'hFF underrun bytes.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h67,
  parameter int         SYNC_STAGES = 2
) (
  input logic        i2c_core_clk_i,
  input logic        i2c_rst_i,
  i2c_slave_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic                   scl_prev_reg, sda_prev_reg;
  logic [3:0]             bit_cnt_reg, bit_cnt_next;
  logic [7:0]             shift_reg, shift_next;
  logic [7:0]             rx_data_reg, rx_data_next;
  logic                   rx_valid_reg, rx_valid_next;
  logic                   tx_ready_reg, tx_ready_next;
  logic                   sda_out_reg, sda_out_next;
  logic                   addr_match_reg, addr_match_next;
  logic                   rw_reg, rw_next;
  logic                   nack_reg, nack_next;
  logic                   underrun_reg, underrun_next;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic                   stretch_reg, stretch_next;
`endif

  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;
  logic load_rd, drive_msb;

  assign scl       = scl_sync_reg[SYNC_STAGES-1];
  assign sda       = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_prev_reg;
  assign scl_fall  = ~scl & scl_prev_reg;
  assign start_det = scl & scl_prev_reg & sda_prev_reg & ~sda;
  assign stop_det  = scl & scl_prev_reg & ~sda_prev_reg & sda;

  always_ff @(posedge i2c_core_clk_i) begin
    if (i2c_rst_i) begin
      scl_sync_reg   <= '1;
      sda_sync_reg   <= '1;
      scl_prev_reg   <= 1'b1;
      sda_prev_reg   <= 1'b1;
      state_reg      <= IDLE;
      bit_cnt_reg    <= 4'd0;
      shift_reg      <= 8'h00;
      rx_data_reg    <= 8'h00;
      rx_valid_reg   <= 1'b0;
      tx_ready_reg   <= 1'b0;
      sda_out_reg    <= 1'b1;
      addr_match_reg <= 1'b0;
      rw_reg         <= 1'b0;
      nack_reg       <= 1'b0;
      underrun_reg   <= 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretch_reg    <= 1'b0;
`endif
    end else begin
      scl_sync_reg   <= {scl_sync_reg[SYNC_STAGES-2:0], bus.i2c_scl_i};
      sda_sync_reg   <= {sda_sync_reg[SYNC_STAGES-2:0], bus.i2c_sda_i};
      scl_prev_reg   <= scl;
      sda_prev_reg   <= sda;
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      tx_ready_reg   <= tx_ready_next;
      sda_out_reg    <= sda_out_next;
      addr_match_reg <= addr_match_next;
      rw_reg         <= rw_next;
      nack_reg       <= nack_next;
      underrun_reg   <= underrun_next;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretch_reg    <= stretch_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    rx_data_next    = rx_data_reg;
    rx_valid_next   = 1'b0;
    tx_ready_next   = 1'b0;
    sda_out_next    = sda_out_reg;
    addr_match_next = addr_match_reg;
    rw_next         = rw_reg;
    nack_next       = nack_reg;
    underrun_next   = underrun_reg;
    load_rd         = 1'b0;
    drive_msb       = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    stretch_next    = stretch_reg;
`endif
    if (start_det) begin
      state_next      = ADDR;
      bit_cnt_next    = 4'd0;
      sda_out_next    = 1'b1;
      addr_match_next = 1'b0;
      nack_next       = 1'b0;
      underrun_next   = 1'b0;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretch_next    = 1'b0;
`endif
    end else if (stop_det) begin
      state_next   = IDLE;
      sda_out_next = 1'b1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      stretch_next = 1'b0;
`endif
    end else begin
      case (state_reg)
        ADDR: if (scl_rise) begin
          shift_next   = {shift_reg[6:0], sda};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          // shift_reg[6:0] already holds address bits [7:1]; sda is the rw bit
          if (bit_cnt_reg == 4'd7) begin
            if (shift_reg[6:0] == SLAVE_ADDR) begin
              state_next      = ADDR_ACK;
              addr_match_next = 1'b1;
              rw_next         = sda;
            end else begin
              state_next = WAIT_STOP;
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_out_next = 1'b0;
            end else begin
              sda_out_next = 1'b1;
              bit_cnt_next = 4'd0;
              if (rw_reg) begin
                state_next = RD_DATA;
                load_rd    = 1'b1;
                drive_msb  = 1'b1;
              end else begin
                state_next = WR_DATA;
              end
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_next   = {shift_reg[6:0], sda};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd7) begin
            rx_data_next  = {shift_reg[6:0], sda};
            rx_valid_next = 1'b1;
            state_next    = WR_ACK;
          end
        end
        RD_DATA: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
          if (stretch_reg) begin
            if (bus.tx_valid_i) begin
              shift_next    = bus.data_transmit_i;
              tx_ready_next = 1'b1;
              sda_out_next  = bus.data_transmit_i[7];
              stretch_next  = 1'b0;
            end
          end else
`endif
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'd8) begin
              sda_out_next = 1'b1;
              state_next   = RD_ACK;
            end else begin
              sda_out_next = shift_reg[~bit_cnt_reg[2:0]];
            end
          end
        end
        RD_ACK: if (scl_rise) begin
          // entering on the 9th rise: the MSB goes out on the following fall
          if (!sda) begin
            state_next   = RD_DATA;
            bit_cnt_next = 4'd0;
            load_rd      = 1'b1;
          end else begin
            nack_next  = 1'b1;
            state_next = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end

    if (load_rd) begin
      if (bus.tx_valid_i) begin
        shift_next    = bus.data_transmit_i;
        tx_ready_next = 1'b1;
        if (drive_msb) sda_out_next = bus.data_transmit_i[7];
      end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        stretch_next  = 1'b1;
        sda_out_next  = 1'b1;
`else
        shift_next    = 8'hFF;
        underrun_next = 1'b1;
        if (drive_msb) sda_out_next = 1'b1;
`endif
      end
    end
  end

  assign bus.i2c_sda_o      = sda_out_reg;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  assign bus.i2c_scl_o      = ~stretch_reg;
`else
  assign bus.i2c_scl_o      = 1'b1;
`endif
  assign bus.data_receive_o = rx_data_reg;
  assign bus.rx_valid_o     = rx_valid_reg;
  assign bus.tx_ready_o     = tx_ready_reg;
  assign bus.status_o       = {3'b000, underrun_reg, nack_reg, rw_reg, addr_match_reg,
                               (state_reg != IDLE)};

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave over a wired-AND bus; expectations come from protocol rules.
module tb_i2c_slave;
  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_sda = 1'b1;
  logic m_scl = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rx_pulses = 0;
  int   tx_pulses = 0;
  int   sda_low_cycles = 0;
  int   scl_low_cycles = 0;

  always #5 clk = ~clk;

  i2c_slave_if bus();
  assign bus.i2c_sda_i = m_sda & bus.i2c_sda_o;
  assign bus.i2c_scl_i = m_scl & bus.i2c_scl_o;

  i2c_slave #(.SLAVE_ADDR(7'h67), .SYNC_STAGES(2)) dut (
    .i2c_core_clk_i(clk),
    .i2c_rst_i     (rst),
    .bus           (bus)
  );

  always @(negedge clk) begin
    if (bus.rx_valid_o) rx_pulses++;
    if (bus.tx_ready_o) tx_pulses++;
    if (!bus.i2c_sda_o) sda_low_cycles++;
    if (!bus.i2c_scl_o) scl_low_cycles++;
  end

  function automatic logic exp_ack(input logic [7:0] a);
    return a[7:1] == 7'h67;
  endfunction

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic scl_high();
    m_scl = 1'b1;
    for (int i = 0; i < 2000 && bus.i2c_scl_i !== 1'b1; i++) @(negedge clk);
    if (bus.i2c_scl_i !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL scl_release_timeout: scl=%b required 1", bus.i2c_scl_i);
    end
  endtask

  task automatic m_start();
    m_sda = 1'b1; wait_q();
    scl_high();   wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic m_stop();
    m_sda = 1'b0; wait_q();
    scl_high();   wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; wait_q();
    scl_high(); wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q();
    scl_high(); wait_q();
    b = bus.i2c_sda_i; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack,
                           input logic [7:0] nxt, input logic nxt_valid);
    logic b;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    bus.data_transmit_i = nxt;
    bus.tx_valid_i      = nxt_valid;
    write_bit(~ack);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.i2c_sda_o !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b want 1", bus.i2c_sda_o); end
    n_cmp++; if (bus.i2c_scl_o !== 1'b1) begin n_err++; $display("FAIL reset_scl: got %b want 1", bus.i2c_scl_o); end
    n_cmp++; if (bus.status_o !== 8'h00) begin n_err++; $display("FAIL reset_status: got %h want 00", bus.status_o); end
    n_cmp++; if (bus.data_receive_o !== 8'h00) begin n_err++; $display("FAIL reset_rxdata: got %h want 00", bus.data_receive_o); end
    n_cmp++; if ({bus.rx_valid_o, bus.tx_ready_o} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b want 00", {bus.rx_valid_o, bus.tx_ready_o}); end
    rst = 1'b0;
    wait_q();
    $display("reset done: status=%h", bus.status_o);
  endtask

  task automatic test_write();
    logic [7:0] d;
    logic       a1, a2;
    int         rx0;
    for (int it = 0; it < 4; it++) begin
      d   = (it == 0) ? 8'h31 : 8'($urandom);
      rx0 = rx_pulses;
      m_start();
      write_byte(8'hCE, a1);
      write_byte(d, a2);
      n_cmp++; if (a1 !== 1'b1) begin n_err++; $display("FAIL write_addr_ack: got %b want 1", a1); end
      n_cmp++; if (a2 !== 1'b1) begin n_err++; $display("FAIL write_data_ack: got %b want 1", a2); end
      n_cmp++; if (bus.data_receive_o !== d) begin n_err++; $display("FAIL write_rxdata: got %h want %h", bus.data_receive_o, d); end
      n_cmp++; if (rx_pulses - rx0 !== 1) begin n_err++; $display("FAIL write_rx_pulses: got %0d want 1", rx_pulses - rx0); end
      n_cmp++; if (bus.status_o[2:0] !== 3'b011) begin n_err++; $display("FAIL write_status: got %b want 011", bus.status_o[2:0]); end
      m_stop(); wait_q();
      n_cmp++; if (bus.status_o[0] !== 1'b0) begin n_err++; $display("FAIL write_idle_busy: got %b want 0", bus.status_o[0]); end
      $display("write 0x67 data=%h acks=%b%b rx=%h", d, a1, a2, bus.data_receive_o);
    end
  endtask

  task automatic test_addr_mismatch();
    logic [7:0] a;
    logic       ack, ack2;
    int         rx0, low0;
    for (int it = 0; it < 4; it++) begin
      a = 8'hA0;
      if (it != 0) begin
        a = 8'($urandom);
        while (a[7:1] == 7'h67) a = 8'($urandom);
      end
      rx0 = rx_pulses; low0 = sda_low_cycles;
      m_start();
      write_byte(a, ack);
      write_byte(8'($urandom), ack2);
      n_cmp++; if (ack !== exp_ack(a)) begin n_err++; $display("FAIL nomatch_ack: got %b want %b", ack, exp_ack(a)); end
      n_cmp++; if (ack2 !== 1'b0) begin n_err++; $display("FAIL nomatch_data_ack: got %b want 0", ack2); end
      n_cmp++; if (sda_low_cycles - low0 !== 0) begin n_err++; $display("FAIL nomatch_sda_low: got %0d want 0", sda_low_cycles - low0); end
      n_cmp++; if (rx_pulses - rx0 !== 0) begin n_err++; $display("FAIL nomatch_rx: got %0d want 0", rx_pulses - rx0); end
      n_cmp++; if (bus.status_o[1:0] !== 2'b01) begin n_err++; $display("FAIL nomatch_status: got %b want 01", bus.status_o[1:0]); end
      m_stop(); wait_q();
      n_cmp++; if (bus.status_o[0] !== 1'b0) begin n_err++; $display("FAIL nomatch_idle: got %b want 0", bus.status_o[0]); end
      $display("address byte %h: ack=%b", a, ack);
    end
  endtask

  task automatic test_read();
    logic [7:0] q [3];
    logic [7:0] got;
    logic       ack;
    int         n, tx0;
    for (int it = 0; it < 3; it++) begin
      n = (it == 0) ? 2 : int'($urandom_range(1, 3));
      for (int k = 0; k < 3; k++) q[k] = 8'($urandom);
      if (it == 0) begin q[0] = 8'h5A; q[1] = 8'hC3; end
      tx0 = tx_pulses;
      bus.data_transmit_i = q[0];
      bus.tx_valid_i      = 1'b1;
      m_start();
      write_byte(8'hCF, ack);
      n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL read_addr_ack: got %b want 1", ack); end
      for (int k = 0; k < n; k++) begin
        read_byte(got, k < n - 1, (k + 1 < 3) ? q[(k + 1) % 3] : 8'h00, 1'b1);
        n_cmp++; if (got !== q[k]) begin n_err++; $display("FAIL read_byte%0d: got %h want %h", k, got, q[k]); end
        $display("read byte %0d: %h", k, got);
      end
      n_cmp++; if (tx_pulses - tx0 !== n) begin n_err++; $display("FAIL read_tx_pulses: got %0d want %0d", tx_pulses - tx0, n); end
      n_cmp++; if (bus.status_o[4:2] !== 3'b011) begin n_err++; $display("FAIL read_status: got %b want 011", bus.status_o[4:2]); end
      m_stop(); wait_q();
      bus.tx_valid_i = 1'b0;
    end
  endtask

  task automatic test_underrun();
    logic [7:0] got;
    logic       ack;
    int         tx0, sl0;
    tx0 = tx_pulses; sl0 = scl_low_cycles;
    bus.data_transmit_i = 8'h5A;
    bus.tx_valid_i      = 1'b0;
    m_start();
    write_byte(8'hCF, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL underrun_addr_ack: got %b want 1", ack); end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    fork
      begin
        repeat (40) @(negedge clk);
        bus.tx_valid_i = 1'b1;
      end
    join_none
    read_byte(got, 1'b0, 8'h5A, 1'b0);
    n_cmp++; if (got !== 8'h5A) begin n_err++; $display("FAIL stretch_byte: got %h want 5a", got); end
    n_cmp++; if (scl_low_cycles - sl0 < 40) begin n_err++; $display("FAIL stretch_scl_low: got %0d cycles want >=40", scl_low_cycles - sl0); end
    n_cmp++; if (tx_pulses - tx0 !== 1) begin n_err++; $display("FAIL stretch_tx_pulses: got %0d want 1", tx_pulses - tx0); end
    n_cmp++; if (bus.status_o[4] !== 1'b0) begin n_err++; $display("FAIL stretch_underrun: got %b want 0", bus.status_o[4]); end
`else
    read_byte(got, 1'b0, 8'h5A, 1'b0);
    n_cmp++; if (got !== 8'hFF) begin n_err++; $display("FAIL underrun_byte: got %h want ff", got); end
    n_cmp++; if (tx_pulses - tx0 !== 0) begin n_err++; $display("FAIL underrun_tx_pulses: got %0d want 0", tx_pulses - tx0); end
    n_cmp++; if (scl_low_cycles - sl0 !== 0) begin n_err++; $display("FAIL underrun_scl: got %0d want 0", scl_low_cycles - sl0); end
    n_cmp++; if (bus.status_o[4] !== 1'b1) begin n_err++; $display("FAIL underrun_flag: got %b want 1", bus.status_o[4]); end
`endif
    m_stop(); wait_q();
    bus.tx_valid_i = 1'b0;
    $display("empty-source read: byte=%h status=%h", got, bus.status_o);
  endtask

  task automatic test_repeated_start();
    logic [7:0] d, r, got;
    logic       a1, a2, a3;
    d = 8'($urandom); r = 8'($urandom);
    bus.data_transmit_i = r;
    bus.tx_valid_i      = 1'b1;
    m_start();
    write_byte(8'hCE, a1);
    write_byte(d, a2);
    m_start();
    write_byte(8'hCF, a3);
    n_cmp++; if ({a1, a2, a3} !== 3'b111) begin n_err++; $display("FAIL rstart_acks: got %b want 111", {a1, a2, a3}); end
    n_cmp++; if (bus.status_o[2:0] !== 3'b111) begin n_err++; $display("FAIL rstart_status: got %b want 111", bus.status_o[2:0]); end
    read_byte(got, 1'b0, 8'h00, 1'b0);
    n_cmp++; if (got !== r) begin n_err++; $display("FAIL rstart_read: got %h want %h", got, r); end
    n_cmp++; if (bus.data_receive_o !== d) begin n_err++; $display("FAIL rstart_rxdata: got %h want %h", bus.data_receive_o, d); end
    m_stop(); wait_q();
    $display("write %h, repeated start, read %h", d, got);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, d2;
    logic       a, a2, b;
    int         rx0;
    d = 8'($urandom); d2 = 8'($urandom);
    rx0 = rx_pulses;
    m_start();
    write_byte(8'hCE, a);
    for (int i = 7; i >= 4; i--) write_bit(d[i]);
    m_sda = d[3]; wait_q();
    rst = 1'b1; @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({bus.i2c_sda_o, bus.i2c_scl_o} !== 2'b11) begin n_err++; $display("FAIL midreset_lines: got %b want 11", {bus.i2c_sda_o, bus.i2c_scl_o}); end
    n_cmp++; if (bus.status_o !== 8'h00) begin n_err++; $display("FAIL midreset_status: got %h want 00", bus.status_o); end
    n_cmp++; if (bus.data_receive_o !== 8'h00) begin n_err++; $display("FAIL midreset_rxdata: got %h want 00", bus.data_receive_o); end
    scl_high(); wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
    for (int i = 2; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    n_cmp++; if (b !== 1'b1) begin n_err++; $display("FAIL midreset_no_ack: got sda %b want 1", b); end
    n_cmp++; if (rx_pulses - rx0 !== 0) begin n_err++; $display("FAIL midreset_rx: got %0d want 0", rx_pulses - rx0); end
    m_stop(); wait_q();
    m_start();
    write_byte(8'hCE, a);
    write_byte(d2, a2);
    n_cmp++; if ({a, a2} !== 2'b11) begin n_err++; $display("FAIL postreset_acks: got %b want 11", {a, a2}); end
    n_cmp++; if (bus.data_receive_o !== d2) begin n_err++; $display("FAIL postreset_rxdata: got %h want %h", bus.data_receive_o, d2); end
    n_cmp++; if (rx_pulses - rx0 !== 1) begin n_err++; $display("FAIL postreset_rx: got %0d want 1", rx_pulses - rx0); end
    m_stop(); wait_q();
    $display("reset mid-write, then write %h accepted=%b%b", d2, a, a2);
  endtask

  initial begin
    bus.data_transmit_i = 8'h00;
    bus.tx_valid_i      = 1'b0;
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_underrun();
    test_repeated_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
